// File: rtl/alu_4_chain_issue.sv
// alu_4_chain_issue: runs one 8-bit ADD/SUB/AND/OR/XOR as two nibble issues on an
// external fixed-latency 4-bit ALU, chaining the carry between nibbles for arithmetic.
`default_nettype none

module alu_4_chain_issue #(
  parameter int ALU_LAT = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_z,
  output logic       out_cout,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic       alu_carry_in,
  output logic       alu_end_bar,
  output logic       alu_cmpl_x,
  output logic       alu_cmpl_y,
  output logic       alu_op_xor,
  output logic       alu_op_and,
  output logic       alu_op_arith,
  input  logic [3:0] alu_z,
  input  logic       alu_carry_out
);

  localparam int CW = ($clog2(2*ALU_LAT+2) > 5) ? $clog2(2*ALU_LAT+2) : 5;
  localparam logic [CW-1:0] CAP_LO       = CW'(ALU_LAT);
  localparam logic [CW-1:0] CAP_HI_LOGIC = CW'(ALU_LAT + 1);
  localparam logic [CW-1:0] CAP_HI_ARITH = CW'(2*ALU_LAT + 1);
  localparam logic [2:0]    OP_SUB       = 3'd1;
  localparam logic [2:0]    OP_LAST      = 3'd4;

  typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, WAIT, DONE} state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic [3:0]      xh_q, yh_q, lo_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_cout_q;
  logic [7:0]      out_z_q;
  logic [3:0]      alu_x_q, alu_y_q;
  logic            alu_cin_q, alu_end_q, alu_cmx_q, alu_cmy_q;
  logic            alu_xor_q, alu_and_q, alu_arith_q;
  logic            arith_op;
  logic [CW-1:0]   cap_hi;

  // Returns {xor, and, arith, cmpl_y} for a legal op, zero otherwise.
  function automatic logic [3:0] ctl(input logic [2:0] op);
    case (op)
      3'd0:    ctl = 4'b1010;
      3'd1:    ctl = 4'b1011;
      3'd2:    ctl = 4'b0100;
      3'd3:    ctl = 4'b1100;
      3'd4:    ctl = 4'b1000;
      default: ctl = 4'b0000;
    endcase
  endfunction

  assign cnt_d    = cnt_q + CW'(1);
  assign arith_op = (op_q[2:1] == 2'b00);
  assign cap_hi   = arith_op ? CAP_HI_ARITH : CAP_HI_LOGIC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      xh_q        <= 4'd0;
      yh_q        <= 4'd0;
      lo_q        <= 4'd0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= 8'd0;
      out_cout_q  <= 1'b0;
      alu_x_q     <= 4'd0;
      alu_y_q     <= 4'd0;
      alu_cin_q   <= 1'b0;
      alu_end_q   <= 1'b0;
      alu_cmx_q   <= 1'b0;
      alu_cmy_q   <= 1'b0;
      alu_xor_q   <= 1'b0;
      alu_and_q   <= 1'b0;
      alu_arith_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      // Every cycle is a bubble unless an issue below overrides it.
      alu_x_q     <= 4'd0;
      alu_y_q     <= 4'd0;
      alu_cin_q   <= 1'b0;
      alu_end_q   <= 1'b0;
      alu_cmx_q   <= 1'b0;
      alu_cmy_q   <= 1'b0;
      alu_xor_q   <= 1'b0;
      alu_and_q   <= 1'b0;
      alu_arith_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q  <= in_op;
            xh_q  <= in_x[7:4];
            yh_q  <= in_y[7:4];
            cnt_q <= '0;
            if (in_op <= OP_LAST) begin
              alu_x_q   <= in_x[3:0];
              alu_y_q   <= in_y[3:0];
              alu_cin_q <= (in_op == OP_SUB);
              alu_end_q <= 1'b1;
              {alu_xor_q, alu_and_q, alu_arith_q, alu_cmy_q} <= ctl(in_op);
              state_q   <= ISSUE_LO;
            end else begin
              out_valid_q <= 1'b1;
              out_z_q     <= 8'd0;
              out_cout_q  <= 1'b0;
              state_q     <= DONE;
            end
          end
        end
        ISSUE_LO: begin
          if (!arith_op) begin
            alu_x_q   <= xh_q;
            alu_y_q   <= yh_q;
            alu_end_q <= 1'b1;
            {alu_xor_q, alu_and_q, alu_arith_q, alu_cmy_q} <= ctl(op_q);
            state_q   <= ISSUE_HI;
          end else begin
            state_q <= WAIT;
          end
        end
        ISSUE_HI: state_q <= WAIT;
        WAIT:     state_q <= WAIT;
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Results are taken only at counter-defined cycles, so stray ALU output is ignored.
      if (state_q == ISSUE_LO || state_q == ISSUE_HI || state_q == WAIT) begin
        if (cnt_q == CAP_LO) begin
          lo_q <= alu_z;
          if (arith_op) begin
            alu_x_q   <= xh_q;
            alu_y_q   <= yh_q;
            alu_cin_q <= alu_carry_out;
            alu_end_q <= 1'b1;
            {alu_xor_q, alu_and_q, alu_arith_q, alu_cmy_q} <= ctl(op_q);
            state_q   <= ISSUE_HI;
          end
        end
        if (cnt_q == cap_hi) begin
          out_z_q     <= {alu_z, lo_q};
          out_cout_q  <= arith_op & alu_carry_out;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
      end
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign out_z        = out_z_q;
  assign out_cout     = out_cout_q;
  assign alu_x        = alu_x_q;
  assign alu_y        = alu_y_q;
  assign alu_carry_in = alu_cin_q;
  assign alu_end_bar  = alu_end_q;
  assign alu_cmpl_x   = alu_cmx_q;
  assign alu_cmpl_y   = alu_cmy_q;
  assign alu_op_xor   = alu_xor_q;
  assign alu_op_and   = alu_and_q;
  assign alu_op_arith = alu_arith_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_4_chain_issue.sv
// tb_alu_4_chain_issue: scoreboard bench with a latency-accurate 4-bit ALU model that
// emits junk on bubble cycles; expected results come from plain 8-bit arithmetic.
`default_nettype none

module tb_alu_4_chain_issue;
  localparam int L = 7;

  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] in_op = 3'd0;
  logic [7:0] in_x = 8'd0, in_y = 8'd0;
  logic       in_ready, out_valid, out_cout;
  logic [7:0] out_z;
  logic [3:0] alu_x, alu_y, alu_z;
  logic       alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y;
  logic       alu_op_xor, alu_op_and, alu_op_arith, alu_carry_out;

  alu_4_chain_issue #(.ALU_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_cout(out_cout),
    .alu_x(alu_x), .alu_y(alu_y), .alu_carry_in(alu_carry_in), .alu_end_bar(alu_end_bar),
    .alu_cmpl_x(alu_cmpl_x), .alu_cmpl_y(alu_cmpl_y), .alu_op_xor(alu_op_xor),
    .alu_op_and(alu_op_and), .alu_op_arith(alu_op_arith),
    .alu_z(alu_z), .alu_carry_out(alu_carry_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: result appears L cycles after presentation; bubbles yield junk.
  logic [4:0] pipe [L];
  function automatic logic [4:0] alu_calc();
    logic [3:0] xa, ya;
    xa = alu_cmpl_x ? ~alu_x : alu_x;
    ya = alu_cmpl_y ? ~alu_y : alu_y;
    if (alu_op_arith)                   alu_calc = {1'b0, xa} + {1'b0, ya} + {4'd0, alu_carry_in};
    else if (alu_op_and && alu_op_xor)  alu_calc = {1'b0, xa | ya};
    else if (alu_op_and)                alu_calc = {1'b0, xa & ya};
    else if (alu_op_xor)                alu_calc = {1'b0, xa ^ ya};
    else                                alu_calc = 5'd0;
  endfunction
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= alu_end_bar ? alu_calc() : 5'($urandom);
  end
  assign alu_z         = pipe[L-1][3:0];
  assign alu_carry_out = pipe[L-1][4];

  typedef struct {
    logic [2:0] op;
    logic [7:0] x, y, z;
    logic       c;
    int         acc;
  } exp_t;
  exp_t q[$];

  int tests = 0, fails = 0;
  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                                 input int acc);
    exp_t e;
    logic [8:0] s;
    e.op = op; e.x = x; e.y = y; e.acc = acc; e.c = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, x} + {1'b0, y}; e.z = s[7:0]; e.c = s[8]; end
      3'd1: begin e.z = x - y; e.c = (x >= y); end
      3'd2: e.z = x & y;
      3'd3: e.z = x | y;
      3'd4: e.z = x ^ y;
      default: e.z = 8'd0;
    endcase
    return e;
  endfunction

  function automatic int latency(input logic [2:0] op);
    if (op <= 3'd1) return 3 + 2*L;
    if (op <= 3'd4) return 3 + L;
    return 1;
  endfunction

  // Expected {xor, and, arith, cmpl_y, cmpl_x} for each legal op.
  function automatic int ctl_exp(input logic [2:0] op);
    case (op)
      3'd0: return 5'b10100;
      3'd1: return 5'b10110;
      3'd2: return 5'b01000;
      3'd3: return 5'b11000;
      default: return 5'b10000;
    endcase
  endfunction

  // Monitor / scoreboard
  int   nis = 0;
  bit   pv = 0, chk_rst = 0, hs_prev = 0;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      q.delete(); nis = 0; pv = 0; chk_rst = 1; hs_prev = 0;
    end else begin
      if (chk_rst) begin
        check("reset_outputs", {out_valid, out_z, out_cout}, 0);
        check("reset_in_ready", in_ready, 1);
        chk_rst = 0;
      end
      if (hs_prev) begin
        check("in_ready_after_handshake", in_ready, 1);
        hs_prev = 0;
      end
      if (!alu_end_bar) begin
        check("bubble_zero", {alu_x, alu_y, alu_carry_in, alu_cmpl_x, alu_cmpl_y,
                              alu_op_xor, alu_op_and, alu_op_arith}, 0);
      end else if (q.size() == 0) begin
        check("issue_without_op", 1, 0);
      end else begin
        e = q[0];
        check("ctl", {alu_op_xor, alu_op_and, alu_op_arith, alu_cmpl_y, alu_cmpl_x}, ctl_exp(e.op));
        if (nis == 0) begin
          check("lo_issue_cycle", cyc, e.acc + 1);
          check("lo_operands", {alu_x, alu_y}, {e.x[3:0], e.y[3:0]});
          check("lo_carry_in", alu_carry_in, (e.op == 3'd1));
        end else begin
          check("hi_issue_cycle", cyc, e.acc + ((e.op <= 3'd1) ? 2 + L : 2));
          check("hi_operands", {alu_x, alu_y}, {e.x[7:4], e.y[7:4]});
          if (e.op == 3'd0)      check("hi_carry_in", alu_carry_in, ({1'b0, e.x[3:0]} + {1'b0, e.y[3:0]}) > 5'd15);
          else if (e.op == 3'd1) check("hi_carry_in", alu_carry_in, e.x[3:0] >= e.y[3:0]);
          else                   check("hi_carry_in", alu_carry_in, 0);
        end
        nis++;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("valid_without_op", 1, 0);
        end else begin
          e = q[0];
          if (!pv) check("latency", cyc - e.acc, latency(e.op));
          check("out_z", out_z, e.z);
          check("out_cout", out_cout, e.c);
          check("in_ready_while_done", in_ready, 0);
          if (out_ready) begin
            check("issue_count", nis, (e.op <= 3'd4) ? 2 : 0);
            void'(q.pop_front());
            nis = 0;
            hs_prev = 1;
          end
        end
      end
      pv = out_valid;
    end
  end

  // Consumer with occasional long stalls
  int hold = 0;
  initial forever begin
    @(posedge clk); #1;
    if (hold > 0) begin out_ready = 1'b0; hold--; end
    else if ($urandom % 10 == 0) begin out_ready = 1'b0; hold = 5; end
    else out_ready = ($urandom % 4 != 0);
  end

  task automatic junk();
    in_valid = 1'($urandom); in_op = 3'($urandom); in_x = 8'($urandom); in_y = 8'($urandom);
  endtask

  // Entered and left at posedge+1; drives noise while busy, the real request when idle.
  int last_acc = 0;
  task automatic send(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (in_ready) begin in_valid = 1'b1; in_op = op; in_x = x; in_y = y; end
      else junk();
      @(negedge clk);
      if (in_valid && in_ready && !rst) begin
        q.push_back(model(op, x, y, cyc));
        last_acc = cyc;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] op;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send(3'd0, 8'h3C, 8'h05);
    send(3'd0, 8'hFF, 8'h01);
    send(3'd1, 8'h10, 8'h01);
    send(3'd3, 8'hA5, 8'h0F);
    send(3'd7, 8'h5A, 8'hC3);
    send(3'd0, 8'h00, 8'h00);
    send(3'd1, 8'h00, 8'h01);
    send(3'd2, 8'hF0, 8'h3C);
    send(3'd4, 8'h55, 8'hFF);
    send(3'd5, 8'h11, 8'h22);

    // Reset in the middle of an ADD, then an XOR immediately after.
    send(3'd0, 8'h9E, 8'h47);
    while (cyc < last_acc + 12) begin junk(); @(posedge clk); #1; end
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(3'd4, 8'h0F, 8'hFF);

    for (int n = 0; n < 40; n++) begin
      op = ($urandom % 10 < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      send(op, 8'($urandom), 8'($urandom));
    end

    in_valid = 1'b0;
    for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge clk);
    #1;
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
